// File: rtl/adc_spi_reader.sv
// adc_spi_reader: frames one 16-bit SPI transfer per accepted sample_strobe,
// sending the next channel address and returning the previous conversion.
// Ports:
//   sys_clk, sys_rst       system clock, synchronous active-high reset
//   sample_strobe          one-cycle frame request
//   chan_sel[2:0]          channel to address, captured at frame start
//   AD_CS, AD_SCLK, AD_DIN serial outputs to the ADC (CS low, SCLK idles high)
//   AD_DOUT                serial data from the ADC
//   sample[11:0]           last converted value
//   sample_chan[2:0]       channel that produced sample
//   sample_valid           one-cycle pulse when sample/sample_chan update
//   busy                   high while not idle
//   overrun                one-cycle pulse for a strobe dropped while busy
module adc_spi_reader #(
    parameter int CLK_DIV = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sample_strobe,
    input  logic [2:0]  chan_sel,
    output logic        AD_CS,
    output logic        AD_SCLK,
    output logic        AD_DIN,
    input  logic        AD_DOUT,
    output logic [11:0] sample,
    output logic [2:0]  sample_chan,
    output logic        sample_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;
    logic          r_phase;
    logic [15:0]   r_shift;
    logic [2:0]    r_addr;
    logic [2:0]    r_prev;
    logic          r_cs;
    logic          r_sclk;
    logic          r_din;
    logic [11:0]   r_sample;
    logic [2:0]    r_chan;
    logic          r_valid;
    logic          r_busy;
    logic          r_overrun;

    logic          w_last;
    logic [3:0]    w_bit_next;
    logic          w_din_next;

    assign w_last     = (r_cnt == LAST);
    assign w_bit_next = r_bit + 4'd1;

    // Control word: address sits in bits 2..4, MSB first.
    always_comb begin
        w_din_next = 1'b0;
        case (w_bit_next)
            4'd2:    w_din_next = r_addr[2];
            4'd3:    w_din_next = r_addr[1];
            4'd4:    w_din_next = r_addr[0];
            default: w_din_next = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_phase   <= 1'b0;
            r_shift   <= '0;
            r_addr    <= '0;
            r_prev    <= '0;
            r_cs      <= 1'b1;
            r_sclk    <= 1'b1;
            r_din     <= 1'b0;
            r_sample  <= '0;
            r_chan    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            // The GAP exit cycle is still non-idle, so a strobe there drops.
            r_overrun <= sample_strobe && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (sample_strobe) begin
                        r_state <= S_SETUP;
                        r_cnt   <= '0;
                        r_addr  <= chan_sel;
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (w_last) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_phase <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_din   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (!r_phase) begin
                            // Sample on the edge that raises SCLK.
                            r_phase <= 1'b1;
                            r_sclk  <= 1'b1;
                            r_shift <= {r_shift[14:0], AD_DOUT};
                        end else if (r_bit == 4'd15) begin
                            r_state <= S_HOLD;
                            r_din   <= 1'b0;
                        end else begin
                            r_bit   <= w_bit_next;
                            r_phase <= 1'b0;
                            r_sclk  <= 1'b0;
                            r_din   <= w_din_next;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_last) begin
                        r_state  <= S_GAP;
                        r_cnt    <= '0;
                        r_cs     <= 1'b1;
                        // Data belongs to the channel addressed last frame.
                        r_sample <= r_shift[11:0];
                        r_chan   <= r_prev;
                        r_valid  <= 1'b1;
                        r_prev   <= r_addr;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_cs    <= 1'b1;
                    r_sclk  <= 1'b1;
                    r_din   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign AD_CS        = r_cs;
    assign AD_SCLK      = r_sclk;
    assign AD_DIN       = r_din;
    assign sample       = r_sample;
    assign sample_chan  = r_chan;
    assign sample_valid = r_valid;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

endmodule

// File: doc/adc_spi_reader.md
ADC_SPI_READER -- requirements
Module: adc_spi_reader

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 16, giving the SCLK half-period in sys_clk cycles; legal values are 2 to 255. With a 100 MHz sys_clk the default gives a 3.125 MHz SCLK.
REQ-002 The block SHALL have the following ports:
- sys_clk  input  1  system clock, 100 MHz.
- sys_rst  input  1  synchronous reset, active-high.
- sample_strobe  input  1  one-cycle request to start a conversion frame; normally the 48 kHz next_val pulse.
- chan_sel  input  3  ADC channel to address; captured at frame start.
- AD_CS  output  1  ADC chip select, active-low.
- AD_SCLK  output  1  ADC serial clock; idles high.
- AD_DIN  output  1  control word to the ADC.
- AD_DOUT  input  1  conversion data from the ADC.
- sample  output  12  last converted value, unsigned.
- sample_chan  output  3  channel that produced sample.
- sample_valid  output  1  one-cycle pulse when sample and sample_chan update.
- busy  output  1  high whenever the FSM is not in IDLE.
- overrun  output  1  one-cycle pulse when sample_strobe arrives while busy.

Function
REQ-003 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD and GAP. All outputs SHALL be registered.
REQ-004 IDLE: AD_CS=1, AD_SCLK=1, AD_DIN=0. When sample_strobe=1 the FSM SHALL:
- latch chan_sel into addr_q;
- go to SETUP;
- drive AD_CS=0 in the next cycle (T+1 for a strobe in cycle T).
REQ-005 SETUP SHALL last CLK_DIV cycles with AD_SCLK=1, then go to SHIFT with bit index 0.
REQ-006 SHIFT SHALL generate exactly 16 SCLK periods, each CLK_DIV cycles low followed by CLK_DIV cycles high.
REQ-007 At each SCLK falling edge for bit i (0..15), AD_DIN SHALL change to:
- addr_q[2] for i=2;
- addr_q[1] for i=3;
- addr_q[0] for i=4;
- 0 for every other i.
REQ-008 AD_DOUT SHALL be sampled in the sys_clk cycle in which AD_SCLK is driven high. Bits SHALL be shifted MSB-first into a 16-bit shift register.
REQ-009 After the 16th high phase the FSM SHALL go to HOLD. HOLD SHALL last CLK_DIV cycles with AD_SCLK=1 and AD_CS=0.
REQ-010 At HOLD exit, in the same cycle that AD_CS returns to 1, the block SHALL:
- load sample with shift register bits [11:0];
- load sample_chan with prev_addr;
- pulse sample_valid;
- copy addr_q into prev_addr.
REQ-011 Shift register bits [15:12] SHALL be discarded; the ADC drives them as zero.
REQ-012 GAP SHALL hold AD_CS=1 for CLK_DIV cycles, then return to IDLE. This guarantees minimum CS-high time between frames.
REQ-013 The AD_CS low time per frame SHALL be exactly 34*CLK_DIV cycles. busy SHALL be high from T+1 to T+35*CLK_DIV inclusive.
REQ-014 A sample_strobe in any non-IDLE state SHALL be dropped and SHALL pulse overrun in the next cycle. The frame in progress and addr_q SHALL be unaffected.
REQ-015 A sample_strobe in the same cycle that GAP exits to IDLE SHALL count as busy, i.e. it is dropped and reported by overrun.
REQ-016 Changes on chan_sel during a frame SHALL have no effect until the next accepted strobe.
REQ-017 The data returned in frame N SHALL be attributed to the channel addressed in frame N-1, since the ADC converts the previously addressed channel.
REQ-018 The SCLK phase counter SHALL be sized for CLK_DIV. It SHALL reload to 0 at every phase boundary and never wrap inside a phase.

Reset
REQ-019 While sys_rst=1, at each sys_clk edge:
- the FSM SHALL go to IDLE;
- AD_CS=1, AD_SCLK=1, AD_DIN=0;
- sample=0, sample_chan=0, sample_valid=0, busy=0, overrun=0;
- addr_q=0, prev_addr=0, all counters 0.
REQ-020 sys_rst asserted mid-frame SHALL abort the frame with no sample_valid pulse. AD_CS SHALL go high in the cycle after reset is sampled.
REQ-021 After reset the first frame's data SHALL be reported as channel 0, matching the ADC power-up channel.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Basic frame: CLK_DIV=16, strobe at cycle 0, chan_sel=5, ADC model returns 0x0ABC. Required: AD_CS low in cycles 1..544; exactly 16 SCLK rising edges; DIN high for bits 2 and 4, low for bit 3; sample_valid at cycle 545 with sample=0xABC and sample_chan=0.
- Channel pipeline: second frame with chan_sel=2 and model data 0x0123. Required: sample=0x123, sample_chan=5; DIN bits 2..4 = 0,1,0.
- Overrun: strobe at cycle 0, then at cycle 100, then at the final GAP cycle. Required: two overrun pulses; only one sample_valid; busy low at cycle 561.
- Reset mid-frame: sys_rst pulsed at cycle 300 of a frame. Required: AD_CS=1 and AD_SCLK=1 from cycle 302; no sample_valid; the next frame reports sample_chan=0.
- 48 kHz stream: CLK_DIV=2 with strobe every 2083 cycles over 100 frames, and chan_sel changed mid-frame. Required: no overrun; sample_chan follows the chan_sel captured at each strobe, delayed one frame.
